// File: rtl/bit_timer_pkg.sv
// bit_timer_pkg: shared defaults for the bit-period tap timer.
// Defaults model the USB full-speed 25-sample bit period.
package bit_timer_pkg;

   localparam int DEFAULT_CNT_BITS = 5;
   localparam int DEFAULT_NUM_TAPS = 3;
   localparam int USB_FS_PERIOD    = 25;

   localparam logic [3*DEFAULT_CNT_BITS-1:0] USB_FS_TAPS =
      {5'd25, 5'd16, 5'd8};

   typedef logic [DEFAULT_CNT_BITS-1:0] cnt_t;

endpackage

// File: rtl/bit_tap_timer_tap_compare.sv
// tap_compare: equality of the next count against each tap value.
// Purely combinational; one match bit per tap.
module tap_compare
   import bit_timer_pkg::*;
#(
   parameter int CNT_BITS = DEFAULT_CNT_BITS,
   parameter int NUM_TAPS = DEFAULT_NUM_TAPS
) (
   input  logic [CNT_BITS-1:0] nxt_count,
   input  logic [CNT_BITS-1:0] taps [NUM_TAPS],
   output logic [NUM_TAPS-1:0] match
);

   // one comparator per tap
   always_comb begin
      match = '0;
      for (int i = 0; i < NUM_TAPS; i++) begin
         match[i] = (nxt_count == taps[i]);
      end
   end

endmodule

// File: rtl/bit_tap_timer.sv
// bit_tap_timer: bit-period counter with programmable tap pulses.
// Macro TIMER_PHASE_CAPTURE_EN adds phase_err/phase_valid capture on resync.
module bit_tap_timer
   import bit_timer_pkg::*;
#(
   parameter int CNT_BITS = DEFAULT_CNT_BITS,
   parameter int NUM_TAPS = DEFAULT_NUM_TAPS
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clear,
   input  logic                         count_enable,
   input  logic                         resync,
   input  logic [CNT_BITS-1:0]          period_val,
   input  logic [NUM_TAPS*CNT_BITS-1:0] tap_val,
   output logic [CNT_BITS-1:0]          count_out,
   output logic [NUM_TAPS-1:0]          tap_flags,
   output logic                         bit_done,
   output logic                         start_pulse
`ifdef TIMER_PHASE_CAPTURE_EN
   ,
   output logic [CNT_BITS-1:0]          phase_err,
   output logic                         phase_valid
`endif
);

   localparam logic [CNT_BITS-1:0] ONE = CNT_BITS'(1);

   logic                prev_enable;
   logic [CNT_BITS-1:0] eff_period;
   logic [CNT_BITS-1:0] nxt_count;
   logic                nxt_done;
   logic                nxt_start;
   logic                taps_en;
   logic [NUM_TAPS-1:0] match;
   logic [CNT_BITS-1:0] taps [NUM_TAPS];

   for (genvar g = 0; g < NUM_TAPS; g++) begin : g_taps
      assign taps[g] = tap_val[g*CNT_BITS +: CNT_BITS];
   end

   assign eff_period = (period_val == '0) ? ONE : period_val;

   tap_compare #(
      .CNT_BITS (CNT_BITS),
      .NUM_TAPS (NUM_TAPS)
   ) u_tap_compare (
      .nxt_count (nxt_count),
      .taps      (taps),
      .match     (match)
   );

   // next count and pulse selection, first matching condition wins
   always_comb begin
      nxt_count = count_out;
      nxt_done  = 1'b0;
      nxt_start = 1'b0;
      taps_en   = 1'b0;
      if (clear) begin
         nxt_count = ONE;
      end else if (!count_enable) begin
         nxt_count = count_out;
      end else if (!prev_enable) begin
         nxt_count = ONE;
         nxt_start = 1'b1;
         taps_en   = 1'b1;
      end else if (resync) begin
         nxt_count = ONE;
         taps_en   = 1'b1;
      end else if (count_out >= eff_period) begin
         nxt_count = ONE;
         nxt_done  = 1'b1;
         taps_en   = 1'b1;
      end else begin
         nxt_count = count_out + ONE;
         taps_en   = 1'b1;
      end
   end

   // registered count, pulses and enable history
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_out   <= '0;
         tap_flags   <= '0;
         bit_done    <= 1'b0;
         start_pulse <= 1'b0;
         prev_enable <= 1'b0;
      end else begin
         count_out   <= nxt_count;
         tap_flags   <= taps_en ? match : '0;
         bit_done    <= nxt_done;
         start_pulse <= nxt_start;
         prev_enable <= count_enable;
      end
   end

`ifdef TIMER_PHASE_CAPTURE_EN
   logic resync_hit;

   assign resync_hit = ~clear & count_enable & prev_enable & resync;

   // capture the pre-resync count as the phase error
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_err   <= '0;
         phase_valid <= 1'b0;
      end else begin
         phase_valid <= resync_hit;
         if (resync_hit) begin
            phase_err <= count_out;
         end
      end
   end
`endif

endmodule

// File: tb/tb_bit_tap_timer.sv
// tb_bit_tap_timer: table vectors, directed sequences, random vs model.
// Build with TIMER_PHASE_CAPTURE_EN defined to also check phase capture.
module tb_bit_tap_timer;

   localparam int CB = 5;
   localparam int NT = 3;

   logic             clk;
   logic             rst;
   logic             clear;
   logic             count_enable;
   logic             resync;
   logic [CB-1:0]    period_val;
   logic [NT*CB-1:0] tap_val;
   logic [CB-1:0]    count_out;
   logic [NT-1:0]    tap_flags;
   logic             bit_done;
   logic             start_pulse;
`ifdef TIMER_PHASE_CAPTURE_EN
   logic [CB-1:0]    phase_err;
   logic             phase_valid;
`endif

   bit_tap_timer #(.CNT_BITS(CB), .NUM_TAPS(NT)) dut (
      .clk          (clk),
      .rst          (rst),
      .clear        (clear),
      .count_enable (count_enable),
      .resync       (resync),
      .period_val   (period_val),
      .tap_val      (tap_val),
      .count_out    (count_out),
      .tap_flags    (tap_flags),
      .bit_done     (bit_done),
      .start_pulse  (start_pulse)
`ifdef TIMER_PHASE_CAPTURE_EN
      ,
      .phase_err    (phase_err),
      .phase_valid  (phase_valid)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // behavioural model state
   int m_cnt, m_taps, m_done, m_start, m_perr, m_pval;
   bit m_was_on;

   typedef struct {
      logic          c, e, r;
      logic [CB-1:0] p;
      int            ec;
      int            et;
      int            ed;
      int            es;
   } vec_t;

   vec_t vecs [13];

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0; m_taps = 0; m_done = 0; m_start = 0;
      m_perr = 0; m_pval = 0; m_was_on = 0;
   endtask

   // spec rules expressed in plain integers
   task automatic model_step();
      int eff, nc;
      bit counting;
      eff      = (period_val == 0) ? 1 : int'(period_val);
      nc       = m_cnt;
      counting = 0;
      m_done   = 0;
      m_start  = 0;
      m_pval   = 0;
      if (clear) begin
         nc = 1;
      end else if (!count_enable) begin
         nc = m_cnt;
      end else if (!m_was_on) begin
         nc = 1; m_start = 1; counting = 1;
      end else if (resync) begin
         m_perr = m_cnt; m_pval = 1;
         nc = 1; counting = 1;
      end else if (m_cnt >= eff) begin
         nc = 1; m_done = 1; counting = 1;
      end else begin
         nc = m_cnt + 1; counting = 1;
      end
      m_taps = 0;
      for (int i = 0; i < NT; i++) begin
         if (counting && nc == int'(tap_val[i*CB +: CB]))
            m_taps |= (1 << i);
      end
      m_cnt    = nc;
      m_was_on = count_enable;
   endtask

   task automatic cmp_model(input string tag);
      chk({tag, ".count"}, int'(count_out), m_cnt);
      chk({tag, ".taps"}, int'(tap_flags), m_taps);
      chk({tag, ".done"}, int'(bit_done), m_done);
      chk({tag, ".start"}, int'(start_pulse), m_start);
`ifdef TIMER_PHASE_CAPTURE_EN
      chk({tag, ".perr"}, int'(phase_err), m_perr);
      chk({tag, ".pval"}, int'(phase_valid), m_pval);
`endif
   endtask

   // drive at negedge, model at posedge, caller samples at next negedge
   task automatic cycle(input logic c, input logic e, input logic r);
      clear = c; count_enable = e; resync = r;
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      #2;
      cmp_model("reset");
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; clear = 0; count_enable = 0; resync = 0;
      period_val = 5'd4;
      tap_val = {5'd4, 5'd0, 5'd2};
      model_reset();
      #12;
      cmp_model("por");
      chk("por.count_zero", int'(count_out), 0);
      @(negedge clk);
      rst = 1'b0;

      // table: period 4, taps {2,0,4}
      vecs[0]  = '{0, 1, 0, 5'd4, 1, 0, 0, 1};
      vecs[1]  = '{0, 1, 0, 5'd4, 2, 1, 0, 0};
      vecs[2]  = '{0, 1, 0, 5'd4, 3, 0, 0, 0};
      vecs[3]  = '{0, 1, 0, 5'd4, 4, 4, 0, 0};
      vecs[4]  = '{0, 1, 0, 5'd4, 1, 0, 1, 0};
      vecs[5]  = '{0, 1, 0, 5'd4, 2, 1, 0, 0};
      vecs[6]  = '{0, 1, 1, 5'd4, 1, 0, 0, 0};
      vecs[7]  = '{0, 0, 0, 5'd4, 1, 0, 0, 0};
      vecs[8]  = '{0, 1, 0, 5'd4, 1, 0, 0, 1};
      vecs[9]  = '{1, 1, 0, 5'd4, 1, 0, 0, 0};
      vecs[10] = '{0, 1, 0, 5'd4, 2, 1, 0, 0};
      vecs[11] = '{0, 1, 0, 5'd1, 1, 0, 1, 0};
      vecs[12] = '{0, 1, 0, 5'd0, 1, 0, 1, 0};
      for (int i = 0; i < 13; i++) begin
         period_val = vecs[i].p;
         cycle(vecs[i].c, vecs[i].e, vecs[i].r);
         chk($sformatf("vec%0d.count", i), int'(count_out), vecs[i].ec);
         chk($sformatf("vec%0d.taps", i), int'(tap_flags), vecs[i].et);
         chk($sformatf("vec%0d.done", i), int'(bit_done), vecs[i].ed);
         chk($sformatf("vec%0d.start", i), int'(start_pulse), vecs[i].es);
      end

      // USB full-speed defaults
      period_val = 5'd25;
      tap_val = {5'd25, 5'd16, 5'd8};
      cycle(0, 0, 0);
      do_reset();
      cycle(0, 1, 0);
      chk("fs.start", int'(start_pulse), 1);
      chk("fs.start_cnt", int'(count_out), 1);
      for (int k = 2; k <= 25; k++) begin
         cycle(0, 1, 0);
         chk($sformatf("fs.cnt%0d", k), int'(count_out), k);
         chk($sformatf("fs.tap%0d", k), int'(tap_flags),
             (k == 8) ? 1 : (k == 16) ? 2 : (k == 25) ? 4 : 0);
      end
      cycle(0, 1, 0);
      chk("fs.wrap_cnt", int'(count_out), 1);
      chk("fs.wrap_done", int'(bit_done), 1);
      cmp_model("fs.wrap");

      // pause at 12
      repeat (11) cycle(0, 1, 0);
      chk("pause.at12", int'(count_out), 12);
      for (int k = 0; k < 5; k++) begin
         cycle(0, 0, 0);
         chk("pause.hold", int'(count_out), 12);
         chk("pause.pulses", int'({tap_flags, bit_done, start_pulse}), 0);
      end
      cycle(0, 1, 0);
      chk("pause.restart", int'(count_out), 1);
      chk("pause.start", int'(start_pulse), 1);

      // resync at 20
      repeat (19) cycle(0, 1, 0);
      chk("rs.at20", int'(count_out), 20);
      cycle(0, 1, 1);
      chk("rs.cnt", int'(count_out), 1);
      chk("rs.done", int'(bit_done), 0);
`ifdef TIMER_PHASE_CAPTURE_EN
      chk("rs.perr", int'(phase_err), 20);
      chk("rs.pval", int'(phase_valid), 1);
`endif
      cmp_model("rs");
      cycle(0, 1, 0);
      cmp_model("rs.after");

      // clear with resync at 10
      repeat (8) cycle(0, 1, 0);
      chk("clr.at10", int'(count_out), 10);
      cycle(1, 1, 1);
      chk("clr.cnt", int'(count_out), 1);
      chk("clr.pulses", int'({tap_flags, bit_done, start_pulse}), 0);
`ifdef TIMER_PHASE_CAPTURE_EN
      chk("clr.pval", int'(phase_valid), 0);
      chk("clr.perr", int'(phase_err), 20);
`endif

      // period 0, taps {30,0,1}
      period_val = 5'd0;
      tap_val = {5'd30, 5'd0, 5'd1};
      for (int k = 0; k < 4; k++) begin
         cycle(0, 1, 0);
         chk("p0.cnt", int'(count_out), 1);
         chk("p0.done", int'(bit_done), 1);
         chk("p0.taps", int'(tap_flags), 1);
      end

      // async reset mid-period at 16
      period_val = 5'd25;
      tap_val = {5'd25, 5'd16, 5'd8};
      repeat (15) cycle(0, 1, 0);
      chk("ar.at16", int'(count_out), 16);
      chk("ar.tap16", int'(tap_flags), 2);
      #2;
      rst = 1'b1;
      #1;
      chk("ar.zero", int'({count_out, tap_flags, bit_done, start_pulse}), 0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      cycle(0, 1, 0);
      chk("ar.start", int'(start_pulse), 1);
      chk("ar.cnt", int'(count_out), 1);

      // random traffic against the model
      for (int n = 0; n < 2000; n++) begin
         if ($urandom_range(0, 49) == 0)
            period_val = CB'($urandom_range(0, 31));
         if ($urandom_range(0, 79) == 0)
            tap_val = NT*CB'($urandom);
         if ($urandom_range(0, 599) == 0) begin
            cycle(0, 0, 0);
            do_reset();
         end
         cycle($urandom_range(0, 15) == 0,
               $urandom_range(0, 7) != 0,
               $urandom_range(0, 9) == 0);
         cmp_model("rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bit_tap_timer.md
Name: bit_tap_timer

Overview:
Parametrised bit-period timer for the USB RX datapath. It is the generalised successor of the fixed 8/16/25 sample counter.
- Counts 1..period_val while enabled and raises one-cycle pulses at NUM_TAPS programmable tap counts.
- Flags bit-period wrap and timer start.
- Supports a resync input, so the RX edge detector can re-align bit phase on every data transition.
- Sits between the edge detector and the RX sampling/decode FSM.

Parameters:
CNT_BITS, 5, width of the counter, period and tap values
NUM_TAPS, 3, number of independent tap comparators

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
clear  input  1  synchronous restart: count to 1, all pulses low
count_enable  input  1  timer runs while high
resync  input  1  synchronous phase re-align (edge seen on bus)
period_val  input  CNT_BITS  last count of a bit period; 0 is treated as 1
tap_val  input  NUM_TAPS*CNT_BITS  packed tap counts, tap i at [i*CNT_BITS +: CNT_BITS]
count_out  output  CNT_BITS  current count
tap_flags  output  NUM_TAPS  per-tap one-cycle pulse
bit_done  output  1  one-cycle pulse on period wrap
start_pulse  output  1  one-cycle pulse on count_enable rising edge
phase_err  output  CNT_BITS  count at last resync (only with TIMER_PHASE_CAPTURE_EN)
phase_valid  output  1  phase_err update pulse (only with TIMER_PHASE_CAPTURE_EN)

Behaviour:
- Reset state: count_out=0, tap_flags=0, bit_done=0, start_pulse=0, phase_err=0, phase_valid=0, internal prev_enable=0.
- All outputs are registered. Each cycle uses this priority, first match wins:
  1. clear: nxt_count=1; tap_flags, bit_done and start_pulse go low; prev_enable<=count_enable.
  2. count_enable=0: count holds; all pulses go low.
  3. count_enable & ~prev_enable (rising edge): nxt_count=1, start_pulse=1. resync is ignored this cycle.
  4. resync: nxt_count=1, bit_done=0.
  5. count_out >= max(period_val,1): nxt_count=1, bit_done=1.
  6. Otherwise: nxt_count=count_out+1.
- Tap rule, cases 3-6: tap_flags[i] <= (nxt_count == tap_val[i]). In cases 1-2 all tap_flags are 0.
- A pulse is high exactly in the cycle count_out holds the new value, and lasts one cycle.
- Taps set to 0, or above the effective period, never fire. Multiple taps with equal values fire together.
- Increment cannot overflow, because wrap uses >=. A period_val lowered mid-period below count_out forces a wrap next cycle.
- period_val 0 or 1: count stays 1 and bit_done pulses every enabled cycle.
- prev_enable <= count_enable every non-reset cycle.
- rst mid-period: everything returns to reset state immediately. The first enabled cycle after reset counts as a rising edge.

Optional Feature:
Macro TIMER_PHASE_CAPTURE_EN.
- Defined: phase_err and phase_valid ports exist. In case 4, phase_err<=count_out (pre-resync value) and phase_valid=1 for one cycle. Otherwise phase_valid=0 and phase_err holds. clear does not alter phase_err.
- Undefined: both ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package bit_timer_pkg holds:
  - localparam DEFAULT_CNT_BITS=5
  - DEFAULT_NUM_TAPS=3
  - USB_FS_PERIOD=25
  - USB_FS_TAPS = {8,16,25} (tap0 = 8)
  - typedef cnt_t, logic [DEFAULT_CNT_BITS-1:0]
- One sub-module, tap_compare: combinational nxt_count vs unpacked tap array, producing the NUM_TAPS match vector. It is generated once in the top.

Test Plan:
- Defaults, period=25, taps {8,16,25}; release rst, assert count_enable → start_pulse with count_out=1. tap_flags[0] 7 cycles later at count 8, [1] at 16, [2] at 25. Next cycle count_out=1 with bit_done=1.
- Drop count_enable at count 12 for 5 cycles → count_out holds 12, no pulses. Re-raise → start_pulse and count_out=1, not 13.
- resync at count 20 → count_out=1 next cycle, bit_done=0. With macro: phase_err=20, phase_valid=1 for one cycle.
- clear and resync together at count 10 → count_out=1, no pulses, phase_valid=0.
- period_val=0, tap {1,0,30} → count stays 1, bit_done and tap_flags[0] high every enabled cycle; taps 1,2 never fire.
- Assert rst asynchronously at count 16 between clock edges → outputs go to 0 at once. After release, the first enabled cycle gives start_pulse.
